// File: rtl/i2c_master_if.sv
// Command handshake and I2C bus pins shared by the single-byte I2C initiator and its controller.
// sda_in carries the resolved open-drain level; the initiator only ever pulls low via sda_oe.
interface i2c_master_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;
    logic       scl_out;
    logic       sda_oe;
    logic       sda_in;

    modport master (
        input  start, rw, addr, wdata, sda_in,
        output busy, done, ack_err, rdata, scl_out, sda_oe
    );

    modport slave (
        output start, rw, addr, wdata, sda_in,
        input  busy, done, ack_err, rdata, scl_out, sda_oe
    );
endinterface

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// done rises on the 80*CLK_DIV-th clk edge after the accept edge (44*CLK_DIV on address NACK).
//
// state    | meaning
// IDLE     | bus released, waiting for start
// START    | SDA falls while SCL high, then SCL low
// ADDR     | eight address/RW bit slots
// ADDR_ACK | target acknowledges the address
// WDATA    | eight write-data bit slots
// WACK     | target acknowledges the write byte
// RDATA    | eight read bit slots, SDA released
// RNACK    | master NACKs the read byte, rdata loaded
// STOP     | SDA rises while SCL high
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic    clk,
    input  logic    reset,
    i2c_master_if.master bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] QMAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_RNACK, S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qidx_q, qidx_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rsh_q, rsh_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          rw_q, rw_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;

    logic last_clk, slot_end, sample;

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        qidx_d    = qidx_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        wdata_d   = wdata_q;
        rsh_d     = rsh_q;
        rdata_d   = rdata_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;

        last_clk = (qcnt_q == QMAX);
        slot_end = last_clk && (qidx_q == 2'd3);
        sample   = (qidx_q == 2'd3) && (qcnt_q == '0);

        if (state_q != S_IDLE) begin
            qcnt_d = last_clk ? '0 : qcnt_q + CW'(1);
            if (last_clk) qidx_d = qidx_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    shreg_d   = {bus.addr, bus.rw};
                    wdata_d   = bus.wdata;
                    rw_d      = bus.rw;
                    busy_d    = 1'b1;
                    ack_err_d = 1'b0;
                    qcnt_d    = '0;
                    qidx_d    = 2'd0;
                    bitcnt_d  = 3'd0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (slot_end) begin
                    bitcnt_d = 3'd0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR, S_WDATA: begin
                if (slot_end) begin
                    shreg_d  = {shreg_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WACK;
                end
            end
            S_ADDR_ACK: begin
                if (sample && bus.sda_in) ack_err_d = 1'b1;
                // ack_err_q is already updated here because the sample clk precedes slot_end
                if (slot_end) begin
                    bitcnt_d = 3'd0;
                    if (ack_err_q) begin
                        state_d = S_STOP;
                    end else if (rw_q) begin
                        state_d = S_RDATA;
                    end else begin
                        shreg_d = wdata_q;
                        state_d = S_WDATA;
                    end
                end
            end
            S_WACK: begin
                if (sample && bus.sda_in) ack_err_d = 1'b1;
                if (slot_end) state_d = S_STOP;
            end
            S_RDATA: begin
                if (sample) rsh_d = {rsh_q[6:0], bus.sda_in};
                if (slot_end) begin
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_RNACK;
                end
            end
            S_RNACK: begin
                if (slot_end) begin
                    rdata_d = rsh_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    qcnt_d  = '0;
                    qidx_d  = 2'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus levels are derived from the next quarter so the pins register in step with it
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            S_START: begin
                scl_d    = (qidx_d != 2'd3);
                sda_oe_d = qidx_d[1];
            end
            S_ADDR, S_WDATA: begin
                scl_d    = qidx_d[1];
                sda_oe_d = ~shreg_d[7];
            end
            S_ADDR_ACK, S_WACK, S_RDATA, S_RNACK: begin
                scl_d    = qidx_d[1];
                sda_oe_d = 1'b0;
            end
            S_STOP: begin
                scl_d    = (qidx_d != 2'd0);
                sda_oe_d = ~qidx_d[1];
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            qidx_q    <= 2'd0;
            bitcnt_q  <= 3'd0;
            shreg_q   <= 8'h00;
            wdata_q   <= 8'h00;
            rsh_q     <= 8'h00;
            rdata_q   <= 8'h00;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            qidx_q    <= qidx_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            wdata_q   <= wdata_d;
            rsh_q     <= rsh_d;
            rdata_q   <= rdata_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
    assign bus.rdata   = rdata_q;
    assign bus.scl_out = scl_q;
    assign bus.sda_oe  = sda_oe_q;
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a bus-level target model decodes the trace and answers ACK/read data,
// transactions come from a vector table, and expected results are queued then popped at done.
module tb_i2c_master;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    i2c_master_if bus();

    i2c_master #(.CLK_DIV(D)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    always #5 clk = ~clk;

    // Target model configuration and open-drain resolution
    logic       tgt_pull;
    logic       t_ack_addr, t_ack_data;
    logic [7:0] t_rbyte;
    assign bus.sda_in = ~(bus.sda_oe | tgt_pull);

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       ack_addr;
        logic       ack_data;
        logic [7:0] rbyte;
        logic [7:0] exp_addr_byte;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data_byte;
        logic       ack1;
        logic       err;
        int         lat;
        logic [7:0] rdata;
        int         rises;
        logic       has_data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_rdata;

    // Bus monitor state
    logic       prev_scl, prev_sda;
    int         m_bitn, m_byten, m_rises, m_starts = 0, m_stops = 0;
    logic [7:0] m_byte, m_addr_byte, m_data_byte;
    logic       m_addr_acked, m_ack1;

    function automatic logic target_drive(input int bitn, input int byten);
        if (byten == 0 && bitn == 8) return t_ack_addr;
        if (byten == 1 && m_addr_acked) begin
            if (m_addr_byte[0]) return (bitn < 8) ? !t_rbyte[7 - bitn] : 1'b0;
            else                return (bitn == 8) ? t_ack_data : 1'b0;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            tgt_pull     <= 1'b0;
            prev_scl     <= 1'b1;
            prev_sda     <= 1'b1;
            m_bitn       <= 0;
            m_byten      <= 0;
            m_addr_acked <= 1'b0;
        end else begin
            if (bus.scl_out && prev_scl && prev_sda && !bus.sda_in) begin
                m_starts     <= m_starts + 1;
                m_bitn       <= 0;
                m_byten      <= 0;
                m_rises      <= 0;
                m_addr_acked <= 1'b0;
                m_addr_byte  <= 8'h00;
                m_data_byte  <= 8'h00;
                m_ack1       <= 1'b0;
            end else if (bus.scl_out && prev_scl && !prev_sda && bus.sda_in) begin
                m_stops <= m_stops + 1;
            end else if (bus.scl_out && !prev_scl) begin
                m_rises <= m_rises + 1;
                if (m_bitn < 8) begin
                    m_byte <= {m_byte[6:0], bus.sda_in};
                    m_bitn <= m_bitn + 1;
                end else begin
                    if (m_byten == 0) begin
                        m_addr_byte  <= m_byte;
                        m_addr_acked <= !bus.sda_in;
                    end else if (m_byten == 1) begin
                        m_data_byte <= m_byte;
                        m_ack1      <= bus.sda_in;
                    end
                    m_bitn  <= 0;
                    m_byten <= m_byten + 1;
                end
            end else if (!bus.scl_out && prev_scl) begin
                tgt_pull <= target_drive(m_bitn, m_byten);
            end
            prev_scl <= bus.scl_out;
            prev_sda <= bus.sda_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives start at the current time (just after a posedge); returns in the done cycle.
    task automatic run_txn(input vec_t v, input int inject_at);
        exp_t e, g;
        int   n, s_starts, s_stops;
        logic got;
        e.addr_byte = v.exp_addr_byte;
        e.has_data  = v.ack_addr;
        e.data_byte = v.rw ? v.rbyte : v.wdata;
        e.ack1      = v.rw ? 1'b1 : !v.ack_data;
        e.err       = v.exp_err;
        e.lat       = v.exp_lat;
        e.rises     = v.ack_addr ? 19 : 10;
        if (v.rw && v.ack_addr) exp_rdata = v.rbyte;
        e.rdata     = exp_rdata;
        sb.push_back(e);

        t_ack_addr = v.ack_addr;
        t_ack_data = v.ack_data;
        t_rbyte    = v.rbyte;
        s_starts   = m_starts;
        s_stops    = m_stops;
        bus.rw     = v.rw;
        bus.addr   = v.addr;
        bus.wdata  = v.wdata;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_accept", bus.busy, 1);

        n = 0;
        got = 1'b0;
        while (!got && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (n == inject_at) begin
                bus.start = 1'b1;
                bus.addr  = ~v.addr;
                bus.rw    = ~v.rw;
            end else begin
                bus.start = 1'b0;
                bus.addr  = v.addr;
                bus.rw    = v.rw;
            end
            if (bus.done) got = 1'b1;
        end
        g = sb.pop_front();
        if (!got) begin
            chk("done_timeout", 32'(n), 32'(g.lat));
        end else begin
            chk("latency", 32'(n), 32'(g.lat));
            chk("ack_err", bus.ack_err, g.err);
            chk("rdata", bus.rdata, g.rdata);
            chk("busy_at_done", bus.busy, 0);
            chk("addr_byte", m_addr_byte, g.addr_byte);
            chk("scl_rises", 32'(m_rises), 32'(g.rises));
            chk("start_edges", 32'(m_starts - s_starts), 1);
            chk("stop_edges", 32'(m_stops - s_stops), 1);
            if (g.has_data) begin
                chk("data_byte", m_data_byte, g.data_byte);
                chk("data_ack_bit", m_ack1, g.ack1);
            end
        end
    endtask

    task automatic idle_after_done(input int cycles);
        @(posedge clk); #1;
        chk("done_one_cycle", bus.done, 0);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    vec_t vt[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 7'h5A, 8'hC3, 1'b1, 1'b1, 8'h00, 8'hB4, 1'b0, 80*D};
        vt[1] = '{1'b1, 7'h21, 8'h00, 1'b1, 1'b1, 8'h96, 8'h43, 1'b0, 80*D};
        vt[2] = '{1'b0, 7'h7F, 8'h55, 1'b0, 1'b1, 8'h00, 8'hFE, 1'b1, 44*D};
        vt[3] = '{1'b0, 7'h33, 8'h0F, 1'b1, 1'b0, 8'h00, 8'h66, 1'b1, 80*D};
        vt[4] = '{1'b1, 7'h10, 8'h00, 1'b1, 1'b1, 8'h5C, 8'h21, 1'b0, 80*D};
        vt[5] = '{1'b0, 7'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 80*D};
        vt[6] = '{1'b1, 7'h44, 8'h00, 1'b0, 1'b1, 8'hA5, 8'h89, 1'b1, 44*D};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.rw     = 1'b0;
        bus.addr   = 7'h00;
        bus.wdata  = 8'h00;
        t_ack_addr = 1'b0;
        t_ack_data = 1'b0;
        t_rbyte    = 8'h00;
        exp_rdata  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", bus.scl_out, 1);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ack_err", bus.ack_err, 0);
        chk("rst_rdata", bus.rdata, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vt[i], 0);
            idle_after_done(4);
            chk("idle_scl", bus.scl_out, 1);
            chk("idle_sda_oe", bus.sda_oe, 0);
        end

        // Start pulsed mid-transaction with a different address must leave the trace untouched
        run_txn(vt[0], 100);
        idle_after_done(4);

        // Back-to-back: start asserted in the done cycle is accepted
        run_txn(vt[0], 0);
        run_txn(vt[4], 0);
        idle_after_done(4);

        // Reset in the RDATA bit-3 slot of a read
        t_ack_addr = 1'b1;
        t_ack_data = 1'b1;
        t_rbyte    = 8'h96;
        bus.rw     = 1'b1;
        bus.addr   = 7'h21;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (214) @(posedge clk);
        #1;
        chk("rdata_held_mid_read", bus.rdata, exp_rdata);
        chk("busy_mid_read", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_scl", bus.scl_out, 1);
        chk("midrst_sda_oe", bus.sda_oe, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_rdata", bus.rdata, 0);
        exp_rdata = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        run_txn(vt[0], 0);
        idle_after_done(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-byte I2C initiator that drives SCL and SDA toward an I2C target, such as the team's `I2C_slave`.
- Each transaction is START, 7-bit address + R/W, target ACK, one data byte, ACK/NACK, then STOP.
- Command side is a simple start/done handshake from a local controller or testbench.
- SDA is open-drain: the block only pulls it low or releases it. SCL is push-pull, and clock stretching is not supported.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-phase. Legal range is ≥2, so one SCL period is 4*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only while busy=0
- rw  input  1  0 = write, 1 = read; captured with start
- addr  input  7  target address; captured with start
- wdata  input  8  write byte; captured with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the transaction ends
- ack_err  output  1  valid with done; 1 = address or write-data NACK
- rdata  output  8  read byte; valid from done until the next accepted start
- scl_out  output  1  SCL level
- sda_oe  output  1  1 = pull SDA low, 0 = release (bus reads 1)
- sda_in  input  1  resolved SDA bus level

Behaviour:
- Reset (synchronous): on the next clk edge all of the following are forced, regardless of state.
  - state=IDLE, scl_out=1, sda_oe=0.
  - busy=0, done=0, ack_err=0, rdata=0, counters=0.
  - This also applies mid-transaction; no STOP is generated.
- Timing unit: each state step is 4 quarters q0..q3, each CLK_DIV clks long. A quarter counter wraps at CLK_DIV-1, then the quarter index advances.
- Command acceptance:
  - In IDLE, start=1 latches `shreg = {addr, rw}`, wdata and rw, sets busy=1, clears ack_err, and enters START.
  - start while busy=1 is ignored.
- START: q0,q1 SCL=1 SDA released; q2 SCL=1 SDA low (START edge); q3 SCL=0 SDA low.
- Bit slot, used by every data and ACK bit:
  - q0,q1: SCL=0; SDA is updated at q0 entry.
  - q2,q3: SCL=1.
  - sda_in is sampled on the first clk of q3.
- ADDR: 8 bit slots, shreg MSB first. A 0 bit sets sda_oe=1; a 1 bit sets sda_oe=0.
- ADDR_ACK: SDA released, sda_in sampled.
  - sda_in=1: ack_err=1, go to STOP.
  - rw=0: go to WDATA.
  - rw=1: go to RDATA.
- WDATA: 8 slots carrying the latched wdata, MSB first.
- WACK: SDA released and sda_in sampled. If sda_in=1, ack_err=1. Always proceed to STOP.
- RDATA: SDA released for 8 slots; each sample shifts into the read shift register at the LSB.
- RNACK: master releases SDA for one slot (NACK, single-byte read); rdata is loaded from the read shift register.
- STOP: q0 SCL=0 SDA low; q1 SCL=1 SDA low; q2,q3 SCL=1 SDA released (STOP edge at q2).
- End of STOP (last clk of q3):
  - The next cycle drives done=1 for one clk and busy=0, and returns to IDLE.
  - A start in that same cycle is accepted.
- Latency:
  - Full transaction = 20 slots = 80*CLK_DIV clks from the accept edge to the done pulse (±1 clk for registering; the implementation documents the exact value and the bench checks it).
  - Address-NACK transaction = 11 slots = 44*CLK_DIV.
- IDLE levels: scl_out=1, sda_oe=0.
- Slot-boundary rule: SDA changes only while SCL=0, except for the START and STOP edges.
- rdata is unchanged on write transactions and on address NACK.

Test Plan:
- Write, CLK_DIV=4, addr=0x5A, rw=0, wdata=0xC3, target ACKs both bytes:
  - Address byte on the bus is 0xB4, data byte is 0xC3, MSB first.
  - START and STOP edges occur while SCL=1.
  - done after 320 clks, ack_err=0, busy low afterwards.
- Read, addr=0x21, rw=1, target ACKs and drives 0x96:
  - Address byte is 0x43.
  - Master NACKs the data byte (SDA released at the 9th slot).
  - rdata=0x96 at done.
- Address NACK, addr=0x7F, sda_in held 1:
  - STOP follows the ACK slot with no data slots.
  - done after 176 clks, ack_err=1.
- Write-data NACK: target ACKs the address and NACKs the data → full-length transaction, ack_err=1.
- start pulsed again mid-transaction with different addr → ignored; the bus trace is identical to the single-transaction case. A back-to-back start in the done cycle is accepted.
- reset asserted during the RDATA bit 3 slot:
  - Next edge: scl_out=1, sda_oe=0, busy=0, done=0, rdata=0.
  - After reset releases, a new write completes normally.
